dmem_responder: RTL and testbench

Data-memory responder for the `rv32e_cpu` data port: it is the slave end of the CPU's `dmem_*` load/store interface, which the CPU drives as initiator. It serves a word-addressed RAM with byte-enable stores and registered (one-wait-state) loads. It also exposes a small MMIO window: a console byte FIFO drained by the simulation harness, a status word, and a free-running cycle counter. It adds a `dmem_ready` handshake so the CPU can be stalled on loads and on console back-pressure.

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave for the rv32e_cpu dmem port: word RAM with byte-enable stores,
// one-wait-state registered loads, and an MMIO window (console FIFO, status, cycle counter).
module dmem_responder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic [3:0]  dmem_byte_enable,
  input  logic        dmem_read,
  input  logic        dmem_write,
  output logic [31:0] dmem_data_in,
  output logic        dmem_ready,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_pop
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e          state_q;
  logic [31:0]     ram_q [2**ADDR_W];
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     cycle_q;

  logic              is_mmio;
  logic [ADDR_W-1:0] word;
  logic [1:0]        reg_sel;
  logic              full, empty;
  logic              idle_write, ram_we, push_req, push, pop;
  logic [3:0]        count_sat;
  logic [31:0]       rdata;

  assign is_mmio = (dmem_addr[31:28] == 4'h1);
  assign word    = dmem_addr[ADDR_W+1:2];
  assign reg_sel = dmem_addr[3:2];

  // Address bits above the RAM index alias; the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_addr[27:ADDR_W+2], dmem_addr[1:0]};

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign idle_write = (state_q == StIdle) && dmem_write && !reset;
  assign ram_we     = idle_write && !is_mmio;
  assign push_req   = idle_write && is_mmio && (reg_sel == 2'd0) && dmem_byte_enable[0];
  assign push       = push_req && !full;
  assign pop        = con_pop && !empty;

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    count_sat = 4'd15;
    if (32'(count_q) < 32'd15) count_sat = 4'(count_q);
  end

  always_comb begin
    rdata = ram_q[word];
    if (is_mmio) begin
      case (reg_sel)
        2'd1:    rdata = {26'b0, full, empty, count_sat};
        2'd2:    rdata = cycle_q;
        default: rdata = '0;
      endcase
    end
  end

  // Writes win over reads; only a console push into a full FIFO stalls a store.
  always_comb begin
    dmem_ready = 1'b1;
    if (state_q == StIdle) begin
      if (dmem_write)     dmem_ready = !(push_req && full);
      else if (dmem_read) dmem_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dmem_data_in <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (dmem_read && !dmem_write) begin
            dmem_data_in <= rdata;
            state_q      <= StResp;
          end
        end
        StResp: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_byte_enable[i]) ram_q[word][8*i +: 8] <= dmem_data_out[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= dmem_data_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a behavioural RAM/FIFO/counter model.
module tb_dmem_responder;

  localparam int unsigned AddrW = 8;
  localparam int unsigned Depth = 8;
  localparam logic [31:0] ConAddr = 32'h1000_0000;
  localparam logic [31:0] StaAddr = 32'h1000_0004;
  localparam logic [31:0] CycAddr = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_addr, dmem_data_out, dmem_data_in;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_read, dmem_write, dmem_ready;
  logic        con_valid, con_pop;
  logic [7:0]  con_data;

  dmem_responder #(.ADDR_W(AddrW), .FIFO_DEPTH(Depth)) dut (
    .clk              (clk),
    .reset            (reset),
    .dmem_addr        (dmem_addr),
    .dmem_data_out    (dmem_data_out),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_data_in     (dmem_data_in),
    .dmem_ready       (dmem_ready),
    .con_valid        (con_valid),
    .con_data         (con_data),
    .con_pop          (con_pop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: RAM image, console byte queue, clocks elapsed since reset.
  logic [31:0] mem_model [2**AddrW];
  logic [7:0]  q[$];
  logic [31:0] cyc_model;

  always @(posedge clk) begin
    if (reset) cyc_model <= 32'd0;
    else       cyc_model <= cyc_model + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AddrW));
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    logic [31:0] v;
    v = mem_model[word_of(a)];
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    mem_model[word_of(a)] = v;
  endfunction

  function automatic logic [31:0] status_exp();
    int n;
    n = q.size();
    return {26'b0, n == Depth, n == 0, 4'((n > 15) ? 15 : n)};
  endfunction

  function automatic logic [31:0] rand_ram_addr(input int w);
    logic [31:0] a;
    a = ($urandom & ~32'h0000_03FC) | (32'(w) << 2);
    if (a[31:28] == 4'h1) a = a ^ 32'h3000_0000;
    return a;
  endfunction

  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output int waits);
    bit done;
    done = 0;
    waits = 0;
    rdata = '0;
    dmem_addr = addr;
    dmem_data_out = wdata;
    dmem_byte_enable = be;
    dmem_read = rd;
    dmem_write = wr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dmem_ready) begin
        done = 1;
        rdata = dmem_data_in;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    check("xact_complete", 32'(done), 32'd1);
  endtask

  task automatic ram_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    int w;
    xact(1'b0, 1'b1, a, d, be, r, w);
    check("store_waits", 32'(w), 32'd0);
    model_store(a, d, be);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int w;
    xact(1'b1, 1'b0, a, 32'd0, 4'h0, r, w);
    check({tag, "_waits"}, 32'(w), 32'd1);
    check(tag, r, exp);
  endtask

  task automatic con_push(input logic [7:0] b);
    logic [31:0] r;
    int w;
    xact(1'b0, 1'b1, ConAddr, {24'hABCDEF, b}, 4'h1, r, w);
    check("push_waits", 32'(w), 32'd0);
    q.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    con_pop = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(con_valid), 32'd1);
    check({tag, "_data"}, 32'(con_data), 32'(e));
    @(posedge clk);
    #1;
    con_pop = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, c0, c1;
    int w;

    reset = 1'b1;
    dmem_addr = CycAddr;
    dmem_data_out = '0;
    dmem_byte_enable = '0;
    dmem_read = 1'b1;
    dmem_write = 1'b0;
    con_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Read held through reset restarts: one wait cycle, then counter value from first edge.
    @(negedge clk);
    check("rst_data_in", dmem_data_in, 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_data", 32'(con_data), 32'd0);
    check("rst_ready_low", 32'(dmem_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_resp_ready", 32'(dmem_ready), 32'd1);
    check("rst_cycle_val", dmem_data_in, cyc_model - 32'd1);
    check("rst_cycle_le1", 32'(dmem_data_in <= 32'd1), 32'd1);
    @(posedge clk);
    #1;
    dmem_read = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(dmem_ready), 32'd1);
    @(posedge clk);
    #1;

    // Byte-enable merge and aliasing.
    ram_store(32'h0000_0040, 32'h1122_3344, 4'hF);
    ram_store(32'h0000_0040, 32'hAABB_CCDD, 4'b0101);
    rd("be_merge", 32'h0000_0040, 32'h11BB_33DD);
    rd("be_alias", 32'h0000_0040 + 32'(4 * (2**AddrW)), 32'h11BB_33DD);

    // Read/write together: store wins, no response cycle follows.
    xact(1'b1, 1'b1, 32'h0000_0080, 32'h5, 4'hF, r, w);
    check("rw_ready_same_cycle", 32'(w), 32'd0);
    model_store(32'h0000_0080, 32'h5, 4'hF);
    rd("rw_readback", 32'h0000_0080, 32'h5);

    // Random RAM traffic over a 32-word window with random high/low address bits.
    for (int i = 0; i < 32; i++) ram_store(rand_ram_addr(i), $urandom, 4'hF);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = rand_ram_addr(int'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1) ram_store(a, $urandom, 4'($urandom_range(0, 15)));
      else rd("ram_rand", a, mem_model[word_of(a)]);
    end

    // Console: empty-pop and lane-0-disabled pushes are ignored.
    rd("sta_empty", StaAddr, status_exp());
    con_pop = 1'b1;
    @(posedge clk);
    #1;
    con_pop = 1'b0;
    xact(1'b0, 1'b1, ConAddr, 32'h55, 4'hE, r, w);
    check("push_be0_waits", 32'(w), 32'd0);
    rd("sta_after_ignored", StaAddr, status_exp());
    rd("con_reg_read", ConAddr, 32'd0);
    rd("reg3_read", 32'h1000_000C, 32'd0);

    // Back-pressure: fill, stall a ninth push, release it with one pop.
    for (int b = 8'h41; b <= 8'h48; b++) con_push(8'(b));
    rd("sta_full", StaAddr, 32'h28);
    dmem_addr = ConAddr;
    dmem_data_out = 32'h49;
    dmem_byte_enable = 4'h1;
    dmem_write = 1'b1;
    @(negedge clk);
    check("bp_hold", 32'(dmem_ready), 32'd0);
    @(posedge clk);
    #1;
    con_pop = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_ready", 32'(dmem_ready), 32'd0);
    check("bp_pop_head", 32'(con_data), 32'h41);
    @(posedge clk);
    #1;
    con_pop = 1'b0;
    void'(q.pop_front());
    @(negedge clk);
    check("bp_release", 32'(dmem_ready), 32'd1);
    @(posedge clk);
    #1;
    dmem_write = 1'b0;
    q.push_back(8'h49);
    check("bp_queue_len", 32'(q.size()), 32'd8);
    while (q.size() > 0) pop_check("bp_drain");
    @(negedge clk);
    check("bp_valid_fall", 32'(con_valid), 32'd0);
    @(posedge clk);
    #1;

    // Simultaneous push and pop at count 3.
    for (int i = 0; i < 3; i++) con_push(8'($urandom));
    rd("sta_three", StaAddr, status_exp());
    dmem_addr = ConAddr;
    dmem_data_out = 32'h7E;
    dmem_byte_enable = 4'hF;
    dmem_write = 1'b1;
    con_pop = 1'b1;
    @(negedge clk);
    check("pp_ready", 32'(dmem_ready), 32'd1);
    check("pp_head", 32'(con_data), 32'(q[0]));
    @(posedge clk);
    #1;
    dmem_write = 1'b0;
    con_pop = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h7E);
    rd("sta_pp", StaAddr, 32'h03);
    while (q.size() > 0) pop_check("pp_order");

    // Random fill/drain rounds.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = int'($urandom_range(1, Depth));
      for (int i = 0; i < n; i++) con_push(8'($urandom));
      rd("sta_rand", StaAddr, status_exp());
      while (q.size() > 0) pop_check("rand_pop");
    end

    // Back-to-back cycle-counter reads are captured two clocks apart.
    xact(1'b1, 1'b0, CycAddr, 32'd0, 4'h0, c0, w);
    check("cyc0_val", c0, cyc_model - 32'd2);
    xact(1'b1, 1'b0, CycAddr, 32'd0, 4'h0, c1, w);
    check("cyc1_val", c1, cyc_model - 32'd2);
    check("cyc_delta", c1 - c0, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
